// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the BCD/hex counter display: segment glyphs,
// digit maximum and prescaler width.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    // Active-low gfedcba glyphs for 0..F.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [3:0] digit_max(input logic bcd_mode);
        return bcd_mode ? 4'd9 : 4'd15;
    endfunction

    // Prescaler counter width for a given divide ratio; never narrower than 1 bit.
    function automatic int pre_width(input int div);
        int w;
        w = $clog2(div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bcd_counter_display_seg7_decode.sv
// Combinational nibble to seven-segment decoder with a blank override.
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : SEG_LUT[digit];
    end

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit prescaled BCD/hex up-counter with registered, optionally
// leading-zero-blanked seven-segment outputs.
module bcd_counter_display
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50000000,
    parameter int BCD_MODE   = 1
) (
    input  logic                    CLOCK_50,
    input  logic                    RESETN,
    input  logic                    EN,
    input  logic                    CLR,
    input  logic                    LOAD,
    input  logic [4*NUM_DIGITS-1:0] LOAD_VAL,
    input  logic                    BLANK_LZ,
    output logic [4*NUM_DIGITS-1:0] VALUE,
    output logic                    WRAP,
    output logic [7*NUM_DIGITS-1:0] HEX
);

    localparam int               W        = 4 * NUM_DIGITS;
    localparam int               PRE_W    = pre_width(TICK_DIV);
    localparam logic [3:0]       DMAX     = digit_max(BCD_MODE != 0);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]      pre;
    logic                  tick;
    logic [W-1:0]          next_value;
    logic                  carry;
    logic                  all_max;
    logic [W-1:0]          load_clamped;
    logic [NUM_DIGITS:0]   zero_above;
    logic [NUM_DIGITS-1:0] blank;
    logic [7*NUM_DIGITS-1:0] seg_next;

    assign tick = EN && (pre == PRE_LAST);

    // Ripple increment: each digit advances only while every lower digit rolls over.
    always_comb begin
        carry      = 1'b1;
        next_value = VALUE;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (VALUE[4*i +: 4] == DMAX) begin
                    next_value[4*i +: 4] = 4'd0;
                end else begin
                    next_value[4*i +: 4] = VALUE[4*i +: 4] + 4'd1;
                    carry                = 1'b0;
                end
            end
        end
        all_max = carry;
    end

    always_comb begin
        load_clamped = LOAD_VAL;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((BCD_MODE != 0) && (LOAD_VAL[4*i +: 4] > 4'd9)) begin
                load_clamped[4*i +: 4] = 4'd9;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            VALUE <= '0;
            pre   <= '0;
            WRAP  <= 1'b0;
        end else if (CLR) begin
            VALUE <= '0;
            pre   <= '0;
            WRAP  <= 1'b0;
        end else if (LOAD) begin
            VALUE <= load_clamped;
            pre   <= '0;
            WRAP  <= 1'b0;
        end else begin
            WRAP <= tick && all_max;
            if (EN) begin
                pre <= tick ? '0 : pre + PRE_W'(1);
            end
            if (tick) begin
                VALUE <= next_value;
            end
        end
    end

    // A digit above 0 blanks when it and everything above it are zero.
    always_comb begin
        zero_above[NUM_DIGITS] = 1'b1;
        blank                  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above[i] = zero_above[i+1] && (VALUE[4*i +: 4] == 4'd0);
            if (i > 0) begin
                blank[i] = BLANK_LZ && zero_above[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
        seg7_decode u_dec (
            .digit (VALUE[4*g +: 4]),
            .blank (blank[g]),
            .seg   (seg_next[7*g +: 7])
        );
    end

    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            HEX <= {NUM_DIGITS{SEG_ZERO}};
        end else begin
            HEX <= seg_next;
        end
    end

endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed bench for bcd_counter_display: two digits, divide-by-4, BCD and hex
// instances driven from the same stimulus.
module tb_bcd_counter_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  load_val = 8'h00;
    logic        blank_lz = 1'b0;
    logic [7:0]  value;
    logic        wrap;
    logic [13:0] hex;
    logic [7:0]  hvalue;
    logic        hwrap;
    logic [13:0] hhex;

    int vectors = 0;
    int errors  = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    bcd_counter_display #(.NUM_DIGITS(2), .TICK_DIV(4), .BCD_MODE(1)) dut (
        .CLOCK_50(clk), .RESETN(rst_n), .EN(en), .CLR(clr), .LOAD(load),
        .LOAD_VAL(load_val), .BLANK_LZ(blank_lz), .VALUE(value), .WRAP(wrap), .HEX(hex)
    );

    bcd_counter_display #(.NUM_DIGITS(2), .TICK_DIV(4), .BCD_MODE(0)) dut_hex (
        .CLOCK_50(clk), .RESETN(rst_n), .EN(en), .CLR(clr), .LOAD(load),
        .LOAD_VAL(load_val), .BLANK_LZ(blank_lz), .VALUE(hvalue), .WRAP(hwrap), .HEX(hhex)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load_val = v;
        load     = 1'b1;
        step(1);
        load     = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        step(2);
        vectors++;
        if (value !== 8'h00 || wrap !== 1'b0 || hex !== {7'h40, 7'h40}) begin
            $display("FAIL reset: value=%h wrap=%b hex=%h, want 00 0 %h", value, wrap, hex, {7'h40, 7'h40});
            errors++;
        end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_count;
        logic [7:0] exp;
        en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (k % 4 == 0) begin
                exp_q.push_back(8'((((k / 4) / 10) << 4) | ((k / 4) % 10)));
                exp = exp_q.pop_front();
                vectors++;
                if (value !== exp || wrap !== 1'b0) begin
                    $display("FAIL count_k%0d: value=%h wrap=%b, want %h 0", k, value, wrap, exp);
                    errors++;
                end
            end
            if (k == 37) begin
                vectors++;
                if (hex !== {7'h40, 7'h18}) begin
                    $display("FAIL count_hex37: hex=%h, want %h", hex, {7'h40, 7'h18});
                    errors++;
                end
            end
        end
        vectors++;
        if (hvalue !== 8'h0A) begin
            $display("FAIL count_hexmode: value=%h, want 0a", hvalue);
            errors++;
        end
        en = 1'b0;
    endtask

    task automatic test_wrap;
        logic [7:0] exp_v;
        logic       exp_w;
        do_load(8'h98);
        en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            exp_v = (k < 4) ? 8'h98 : (k < 8) ? 8'h99 : 8'h00;
            exp_w = (k == 8);
            vectors++;
            if (value !== exp_v || wrap !== exp_w) begin
                $display("FAIL wrap_k%0d: value=%h wrap=%b, want %h %b", k, value, wrap, exp_v, exp_w);
                errors++;
            end
        end
        en = 1'b0;
    endtask

    task automatic test_load_clamp;
        do_load(8'hAF);
        vectors++;
        if (value !== 8'h99 || hvalue !== 8'hAF) begin
            $display("FAIL load_clamp: bcd=%h hex=%h, want 99 af", value, hvalue);
            errors++;
        end
        step(1);
        vectors++;
        if (hhex !== {7'h08, 7'h0E} || hex !== {7'h18, 7'h18}) begin
            $display("FAIL load_glyph: hexmode=%h bcd=%h, want %h %h", hhex, hex, {7'h08, 7'h0E}, {7'h18, 7'h18});
            errors++;
        end
    endtask

    task automatic test_priority;
        do_load(8'h42);
        en = 1'b1;
        step(3);
        clr = 1'b1; load = 1'b1; load_val = 8'h77;
        step(1);
        clr = 1'b0; load = 1'b0;
        vectors++;
        if (value !== 8'h00 || wrap !== 1'b0) begin
            $display("FAIL clr_over_load: value=%h wrap=%b, want 00 0", value, wrap);
            errors++;
        end
        step(3);
        vectors++;
        if (value !== 8'h00) begin
            $display("FAIL clr_pre_zero3: value=%h, want 00", value);
            errors++;
        end
        step(1);
        vectors++;
        if (value !== 8'h01) begin
            $display("FAIL clr_pre_zero4: value=%h, want 01", value);
            errors++;
        end
        step(3);
        do_load(8'h55);
        vectors++;
        if (value !== 8'h55) begin
            $display("FAIL load_over_tick: value=%h, want 55", value);
            errors++;
        end
        en = 1'b0;
    endtask

    task automatic test_blank;
        logic [7:0]  vals [4] = '{8'h05, 8'h00, 8'h50, 8'h05};
        logic        blz  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [13:0] exps [4] = '{{7'h7F, 7'h12}, {7'h7F, 7'h40}, {7'h12, 7'h40}, {7'h40, 7'h12}};
        for (int i = 0; i < 4; i++) begin
            blank_lz = blz[i];
            do_load(vals[i]);
            step(1);
            vectors++;
            if (hex !== exps[i]) begin
                $display("FAIL blank_%0d: hex=%h, want %h", i, hex, exps[i]);
                errors++;
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_en_hold_async_reset;
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        en = 1'b1;
        step(2);
        en = 1'b0;
        step(5);
        en = 1'b1;
        step(1);
        vectors++;
        if (value !== 8'h00) begin
            $display("FAIL en_hold_a: value=%h, want 00", value);
            errors++;
        end
        step(1);
        vectors++;
        if (value !== 8'h01) begin
            $display("FAIL en_hold_b: value=%h, want 01", value);
            errors++;
        end
        do_load(8'h37);
        step(1);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (value !== 8'h00 || wrap !== 1'b0 || hex !== {7'h40, 7'h40}) begin
            $display("FAIL async_reset: value=%h wrap=%b hex=%h, want 00 0 %h", value, wrap, hex, {7'h40, 7'h40});
            errors++;
        end
        step(1);
        rst_n = 1'b1;
        step(3);
        vectors++;
        if (value !== 8'h00) begin
            $display("FAIL resume3: value=%h, want 00", value);
            errors++;
        end
        step(1);
        vectors++;
        if (value !== 8'h01) begin
            $display("FAIL resume4: value=%h, want 01", value);
            errors++;
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_load_clamp();
        test_priority();
        test_blank();
        test_en_hold_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
